bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Accepts i_bin on i_start while idle; o_done pulses for one cycle when o_bcd updates.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_scratch;
  logic [WIDTH-1:0] r_shift;
  logic [SW-1:0]   r_bcd;
  logic            r_done;

  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [SW-1:0]   w_scratch_next;
  logic [WIDTH-1:0] w_shift_next;
  logic [SW-1:0]   w_bcd_next;
  logic            w_done_next;

  logic [SW-1:0]       w_adj;
  logic [SW+WIDTH-1:0] w_cat;

  // Add-3 correction on every digit in parallel, before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  assign w_cat = {w_adj, r_shift} << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_scratch <= '0;
      r_shift   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_scratch <= w_scratch_next;
      r_shift   <= w_shift_next;
      r_bcd     <= w_bcd_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_scratch_next = r_scratch;
    w_shift_next   = r_shift;
    w_bcd_next     = r_bcd;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next   = S_CONV;
          w_shift_next   = i_bin;
          w_scratch_next = '0;
          w_cnt_next     = '0;
        end
      end
      S_CONV: begin
        w_scratch_next = w_cat[SW+WIDTH-1:WIDTH];
        w_shift_next   = w_cat[WIDTH-1:0];
        w_cnt_next     = r_cnt + CW'(1);
        // Last iteration: publish the result straight from the shifted value.
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_next = S_IDLE;
          w_bcd_next   = w_cat[SW+WIDTH-1:WIDTH];
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_bcd  = r_bcd;
  assign o_busy = (r_state == S_CONV);
  assign o_done = r_done;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver pushes expected results and completion
// edges, a monitor checks busy, held BCD and every done pulse against them.
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int SW     = 4 * DIGITS;

  typedef struct {
    int            edge_n;
    logic [SW-1:0] bcd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin = '0;
  logic [SW-1:0]    bcd;
  logic             busy;
  logic             done;

  int            cyc = 0;
  int            acc_edge = -1000;
  logic [SW-1:0] hold_bcd = '0;
  exp_t          q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bin   (bin),
    .o_bcd   (bcd),
    .o_busy  (busy),
    .o_done  (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by plain division, independent of the shift-and-add method.
  function automatic logic [SW-1:0] ref_bcd(int v);
    logic [SW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(string name, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive one cycle; a start is accepted only when the converter is idle at that edge.
  task automatic step(bit s, logic [WIDTH-1:0] b);
    int e;
    @(negedge clk);
    start = s;
    bin   = b;
    e = cyc + 1;
    if (s && rst_n && (e > acc_edge + WIDTH)) begin
      acc_edge = e;
      q.push_back('{edge_n: e + WIDTH, bcd: ref_bcd(int'(b))});
      $display("issue  bin=%0d at edge %0d expect bcd=%03h at edge %0d",
               b, e, ref_bcd(int'(b)), e + WIDTH);
    end
  endtask

  always begin
    exp_t e;
    bit   exp_busy;
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_busy = (cyc >= acc_edge) && (cyc < acc_edge + WIDTH);
      chk("busy", int'(busy), int'(exp_busy));
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 bcd=%03h expected no done (edge %0d)", bcd, cyc);
        end else begin
          e = q.pop_front();
          chk("done_edge", cyc, e.edge_n);
          chk("bcd", 32'(bcd), 32'(e.bcd));
          hold_bcd = e.bcd;
          $display("done   bcd=%03h at edge %0d", bcd, cyc);
        end
      end else begin
        if (q.size() > 0 && q[0].edge_n <= cyc) begin
          e = q.pop_front();
          n_cmp++;
          n_err++;
          $display("FAIL missed_done: got done=0 expected done at edge %0d (now %0d)", e.edge_n, cyc);
        end
        chk("bcd_hold", 32'(bcd), 32'(hold_bcd));
      end
    end
  end

  initial begin
    int sweep[5];
    sweep = '{9, 10, 99, 100, 128};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_bcd", 32'(bcd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero and maximum operand
    step(1'b1, 8'd0);
    repeat (WIDTH) step(1'b0, 8'($urandom));
    step(1'b1, 8'd255);
    repeat (WIDTH) step(1'b0, 8'($urandom));

    foreach (sweep[i]) begin
      step(1'b1, 8'(sweep[i]));
      repeat (WIDTH) step(1'b0, 8'($urandom));
    end

    // Re-pulsed start during conversion must be ignored
    step(1'b1, 8'd37);
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    step(1'b1, 8'd200);
    repeat (WIDTH) step(1'b0, 8'd0);

    // Start held high: second operand presented on the done cycle
    repeat (WIDTH + 1) step(1'b1, 8'd42);
    repeat (WIDTH + 1) step(1'b1, 8'd199);
    repeat (WIDTH + 1) step(1'b0, 8'd0);

    // Asynchronous reset four edges into a conversion
    step(1'b1, 8'd77);
    repeat (4) step(1'b0, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bcd", 32'(bcd), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    q.delete();
    acc_edge = -1000;
    hold_bcd = '0;
    repeat (3) step(1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'd77);
    repeat (WIDTH) step(1'b0, 8'd0);

    for (int v = 0; v < 256; v++) begin
      step(1'b1, 8'(v));
      repeat (WIDTH) step(1'b0, 8'($urandom));
    end

    repeat (400) step($urandom_range(0, 3) == 0, 8'($urandom));

    repeat (WIDTH + 2) step(1'b0, 8'd0);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
